fetch_unit: RTL

- Instruction-fetch front end for the pipelined MIPS core; the consumer side of next-PC generation.
- Holds the architectural fetch PC and issues in-order word requests to instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers returned instructions with their PCs and delivers them to decode over a valid/ready handshake.
- Accepts a redirect (the resolved target from the next-PC logic); on redirect it flushes the buffer and discards stale in-flight responses.

---
 rtl/fetch_unit_if.sv | 28 ++
 rtl/fetch_unit.sv | 92 +++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Handshake bundles for the fetch front end: instruction-memory
// request/response channel and the decode-facing instruction stream.
interface fetch_imem_if;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;

    modport master (
        output req_valid, req_addr,
        input  req_ready, rsp_valid, rsp_data
    );
    modport slave (
        input  req_valid, req_addr,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

interface fetch_out_if;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        ready;

    modport master (output valid, instr, pc, input ready);
    modport slave  (input valid, instr, pc, output ready);
endinterface

// File: rtl/fetch_unit.sv
// Fetch front end: issues in-order word requests, buffers responses
// with their PCs, and squashes stale in-flight data on redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          DEPTH    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    output logic [31:0]   fetch_pc,
    fetch_imem_if.master  imem,
    fetch_out_if.master   dec
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0]   LIMIT = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0] LAST  = PW'(DEPTH - 1);

    logic [31:0]   pc;
    logic [31:0]   rsp_pc;
    logic [31:0]   buf_pc    [DEPTH];
    logic [31:0]   buf_instr [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [CW-1:0] inflight;
    logic [CW-1:0] drop;
    logic          accept;
    logic          push;
    logic          pop;
    logic          discard;
    logic [31:0]   target;
    logic          unused_ok;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign target    = {redirect_pc[31:2], 2'b00};
    assign unused_ok = ^redirect_pc[1:0];

    assign fetch_pc      = pc;
    assign imem.req_addr = pc;
    // Credit rule: buffered plus outstanding never exceeds DEPTH.
    assign imem.req_valid = !redirect_valid &&
        (({1'b0, count} + {1'b0, inflight}) < LIMIT);

    assign dec.valid = (count != '0) && !redirect_valid;
    assign dec.pc    = buf_pc[head];
    assign dec.instr = buf_instr[head];

    assign accept  = imem.req_valid && imem.req_ready;
    assign discard = imem.rsp_valid && (drop != '0);
    assign push    = imem.rsp_valid && (drop == '0);
    assign pop     = dec.valid && dec.ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            rsp_pc   <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            inflight <= '0;
            drop     <= '0;
        end else if (redirect_valid) begin
            pc       <= target;
            rsp_pc   <= target;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            inflight <= inflight - CW'(imem.rsp_valid);
            drop     <= inflight - CW'(imem.rsp_valid);
        end else begin
            if (accept)
                pc <= pc + 32'd4;
            inflight <= inflight + CW'(accept) - CW'(imem.rsp_valid);
            if (discard)
                drop <= drop - 1'b1;
            if (push) begin
                buf_pc[tail]    <= rsp_pc;
                buf_instr[tail] <= imem.rsp_data;
                tail            <= bump(tail);
                rsp_pc          <= rsp_pc + 32'd4;
            end
            if (pop)
                head <= bump(head);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule
